// File: rtl/multicycle_cpu_p.sv
// Parametrised 5-cycle-per-instruction CPU with program-load port, start/halt control and debug RF read.
// Define CPU_MUL_EN to enable opcode 11 (MUL); otherwise opcode 11 executes as NOP.
module multicycle_cpu_p #(
  parameter int DATA_W    = 10,
  parameter int CMD_DEPTH = 32,
  parameter int MEM_DEPTH = 32,
  parameter int RF_DEPTH  = 16,
  parameter int AW        = 5,
  localparam int CMD_W    = 4 + 2*AW + DATA_W,
  localparam int PW       = $clog2(CMD_DEPTH),
  localparam int MW       = $clog2(MEM_DEPTH),
  localparam int RW       = $clog2(RF_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [PW-1:0]     prog_addr,
  input  logic [CMD_W-1:0]  prog_data,
  input  logic [RW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [PW-1:0]     pc,
  output logic              busy,
  output logic              halted,
  output logic              div0
);

  localparam logic [3:0] OP_LTM  = 4'd1;
  localparam logic [3:0] OP_MTR  = 4'd2;
  localparam logic [3:0] OP_RTR  = 4'd3;
  localparam logic [3:0] OP_JL   = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SUM  = 4'd6;
  localparam logic [3:0] OP_MTRK = 4'd7;
  localparam logic [3:0] OP_RTM  = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
`ifdef CPU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd11;
`endif
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam int F1_LSB = CMD_W - 4 - AW;
  localparam int F2_LSB = CMD_W - 4 - 2*AW;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_OPA, S_OPB, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t state, state_next;

  logic [CMD_W-1:0]  progmem [CMD_DEPTH];
  logic [DATA_W-1:0] dmem    [MEM_DEPTH];
  logic [DATA_W-1:0] rf      [RF_DEPTH];

  logic [CMD_W-1:0]  ir;
  logic [DATA_W-1:0] a, b, res, alu_res;

  logic [3:0]        op;
  logic [RW-1:0]     f1_rf, f2_rf, f3_rf;
  logic [MW-1:0]     f1_mem, f2_mem;
  logic [PW-1:0]     f3_pc;
  logic [DATA_W-1:0] imm;
  logic              ctrl_idle;

  assign op     = ir[CMD_W-1 -: 4];
  assign f1_rf  = ir[F1_LSB +: RW];
  assign f1_mem = ir[F1_LSB +: MW];
  assign f2_rf  = ir[F2_LSB +: RW];
  assign f2_mem = ir[F2_LSB +: MW];
  assign imm    = ir[DATA_W-1:0];
  assign f3_rf  = ir[0 +: RW];
  assign f3_pc  = ir[0 +: PW];

  assign ctrl_idle = (state == S_IDLE) || (state == S_HALT);
  assign busy      = !ctrl_idle;
  assign halted    = (state == S_HALT);
  assign dbg_data  = rf[dbg_addr];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_next = S_FETCH;
      S_FETCH:        state_next = S_OPA;
      S_OPA:          state_next = S_OPB;
      S_OPB:          state_next = S_EXEC;
      S_EXEC:         state_next = S_WB;
      S_WB:           state_next = (op == OP_HLT) ? S_HALT : S_FETCH;
      default:        state_next = S_IDLE;
    endcase
  end

  // Result is latched in EXEC so WB only has to steer it to RF or data memory.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_LTM:  alu_res = imm;
      OP_MTR:  alu_res = dmem[f1_mem];
      OP_MTRK: alu_res = dmem[a[MW-1:0]];
      OP_RTR:  alu_res = b;
      OP_RTM:  alu_res = a;
      OP_SUB:  alu_res = a - b;
      OP_SUM:  alu_res = a + b;
      OP_DIV:  alu_res = (b == '0) ? '1 : a / b;
`ifdef CPU_MUL_EN
      OP_MUL:  alu_res = a * b;
`endif
      default: alu_res = '0;
    endcase
  end

  // Program memory has no reset so a loaded program survives a core reset.
  always_ff @(posedge clk) begin
    if (!reset && prog_we && ctrl_idle) progmem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= '0;
      div0 <= 1'b0;
      ir   <= '0;
      a    <= '0;
      b    <= '0;
      res  <= '0;
      for (int i = 0; i < RF_DEPTH; i++)  rf[i]   <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) dmem[i] <= '0;
      rf[1] <= DATA_W'(1);
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc   <= '0;
            div0 <= 1'b0;
          end
        end
        S_FETCH: ir  <= progmem[pc];
        S_OPA:   a   <= rf[f1_rf];
        S_OPB:   b   <= rf[f2_rf];
        S_EXEC:  res <= alu_res;
        S_WB: begin
          pc <= pc + PW'(1);
          case (op)
            OP_LTM:          dmem[f1_mem] <= res;
            OP_RTM:          dmem[f2_mem] <= res;
            OP_MTR, OP_MTRK: rf[f2_rf]    <= res;
            OP_RTR:          rf[f1_rf]    <= res;
            OP_SUB, OP_SUM:  rf[f3_rf]    <= res;
            OP_DIV: begin
              rf[f3_rf] <= res;
              if (b == '0) div0 <= 1'b1;
            end
`ifdef CPU_MUL_EN
            OP_MUL:          rf[f3_rf]    <= res;
`endif
            OP_JL:           if (!(a < b)) pc <= f3_pc;
            OP_JMP:          pc <= f3_pc;
            OP_HLT:          pc <= pc;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu_p.sv
// Self-checking bench for multicycle_cpu_p: instruction-level reference model compared every cycle,
// plus directed programs with hand-computed results. Honours CPU_MUL_EN like the design.
`timescale 1ns/1ps
module tb_multicycle_cpu_p;
  localparam int DATA_W    = 10;
  localparam int CMD_DEPTH = 32;
  localparam int MEM_DEPTH = 32;
  localparam int RF_DEPTH  = 16;
  localparam int AW        = 5;
  localparam int CMD_W     = 4 + 2*AW + DATA_W;
  localparam int DMAX      = 1 << DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              prog_we = 1'b0;
  logic [4:0]        prog_addr = '0;
  logic [CMD_W-1:0]  prog_data = '0;
  logic [3:0]        dbg_addr = '0;
  logic [DATA_W-1:0] dbg_data;
  logic [4:0]        pc;
  logic              busy, halted, div0;

  int tests = 0;
  int fails = 0;

  logic             model_ok = 1'b0;
  logic             m_busy, m_halted, m_div0;
  int               m_pc, m_phase;
  int               m_rf  [RF_DEPTH];
  int               m_mem [MEM_DEPTH];
  logic [CMD_W-1:0] m_prog [CMD_DEPTH];
  logic [CMD_W-1:0] prog_buf [CMD_DEPTH];

  multicycle_cpu_p #(
    .DATA_W(DATA_W), .CMD_DEPTH(CMD_DEPTH), .MEM_DEPTH(MEM_DEPTH),
    .RF_DEPTH(RF_DEPTH), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .pc(pc), .busy(busy), .halted(halted), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CMD_W-1:0] enc(input int op, input int f1, input int f2, input int imm);
    logic [3:0]        o;
    logic [AW-1:0]     x1, x2;
    logic [DATA_W-1:0] iv;
    o  = 4'(op);
    x1 = AW'(f1);
    x2 = AW'(f2);
    iv = DATA_W'(imm);
    return {o, x1, x2, iv};
  endfunction

  // One instruction applied atomically, using integer arithmetic on the ISA rules.
  task automatic model_exec();
    logic [CMD_W-1:0] c;
    int op, f1, f2, imm, f3, ra, rb, nxt;
    c   = m_prog[m_pc];
    op  = int'(c[CMD_W-1 -: 4]);
    f1  = int'(c[CMD_W-5 -: AW]);
    f2  = int'(c[CMD_W-5-AW -: AW]);
    imm = int'(c[DATA_W-1:0]);
    f3  = imm % (1 << AW);
    ra  = m_rf[f1 % RF_DEPTH];
    rb  = m_rf[f2 % RF_DEPTH];
    nxt = (m_pc + 1) % CMD_DEPTH;
    case (op)
      1:  m_mem[f1 % MEM_DEPTH] = imm;
      2:  m_rf[f2 % RF_DEPTH] = m_mem[f1 % MEM_DEPTH];
      3:  m_rf[f1 % RF_DEPTH] = rb;
      4:  if (!(ra < rb)) nxt = f3 % CMD_DEPTH;
      5:  m_rf[f3 % RF_DEPTH] = (ra - rb + DMAX) % DMAX;
      6:  m_rf[f3 % RF_DEPTH] = (ra + rb) % DMAX;
      7:  m_rf[f2 % RF_DEPTH] = m_mem[ra % MEM_DEPTH];
      8:  m_mem[f2 % MEM_DEPTH] = ra;
      9:  nxt = f3 % CMD_DEPTH;
      10: begin
        if (rb == 0) begin
          m_rf[f3 % RF_DEPTH] = DMAX - 1;
          m_div0 = 1'b1;
        end else begin
          m_rf[f3 % RF_DEPTH] = ra / rb;
        end
      end
`ifdef CPU_MUL_EN
      11: m_rf[f3 % RF_DEPTH] = (ra * rb) % DMAX;
`endif
      15: begin
        m_busy   = 1'b0;
        m_halted = 1'b1;
        nxt      = m_pc;
      end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  // Reference model: every instruction occupies 5 clock edges and commits on the 5th.
  always @(posedge clk) begin
    if (reset) begin
      model_ok = 1'b1;
      m_busy = 1'b0; m_halted = 1'b0; m_div0 = 1'b0; m_pc = 0; m_phase = 0;
      foreach (m_rf[i])  m_rf[i]  = 0;
      foreach (m_mem[i]) m_mem[i] = 0;
      m_rf[1] = 1;
    end else if (!m_busy) begin
      if (prog_we) m_prog[prog_addr] = prog_data;
      if (start) begin
        m_busy = 1'b1; m_halted = 1'b0; m_pc = 0; m_div0 = 1'b0; m_phase = 0;
      end
    end else if (m_phase == 4) begin
      m_phase = 0;
      model_exec();
    end else begin
      m_phase++;
    end
  end

  always @(posedge clk) begin
    #2;
    if (model_ok) begin
      chk("busy",     int'(busy),     int'(m_busy));
      chk("halted",   int'(halted),   int'(m_halted));
      chk("div0",     int'(div0),     int'(m_div0));
      chk("pc",       int'(pc),       m_pc);
      chk("dbg_data", int'(dbg_data), m_rf[dbg_addr]);
    end
  end

  task automatic applyStimulus_reset(input int n);
    @(negedge clk);
    reset = 1'b1; start = 1'b0; prog_we = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_hlt();
    foreach (prog_buf[i]) prog_buf[i] = enc(15, 0, 0, 0);
  endtask

  task automatic load_prog();
    for (int i = 0; i < CMD_DEPTH; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 5'(i); prog_data = prog_buf[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic run_prog(input int max, output int cycles, output int d0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; d0 = int'(div0);
    cycles = 0;
    while (busy && cycles < max) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic read_rf(input int idx, output int val);
    dbg_addr = 4'(idx);
    #1;
    val = int'(dbg_data);
  endtask

  initial begin
    int cyc, d0, v, budget;

    applyStimulus_reset(2);
    chk("reset_busy", int'(busy), 0);
    chk("reset_halted", int'(halted), 0);
    chk("reset_pc", int'(pc), 0);
    read_rf(1, v); chk("reset_rf1", v, 1);

    // Load/move/halt
    fill_hlt();
    prog_buf[0] = enc(1, 3, 0, 7);
    prog_buf[1] = enc(2, 3, 2, 0);
    load_prog();
    run_prog(100, cyc, d0);
    chk("t1_cycles", cyc, 15);
    chk("t1_halted", int'(halted), 1);
    chk("t1_pc", int'(pc), 2);
    read_rf(2, v); chk("t1_rf2", v, 7);

    // Arithmetic wrap, divide by zero, optional multiply
    applyStimulus_reset(1);
    fill_hlt();
    prog_buf[0]  = enc(1, 0, 0, 7);
    prog_buf[1]  = enc(1, 1, 0, 1023);
    prog_buf[2]  = enc(1, 2, 0, 40);
    prog_buf[3]  = enc(1, 3, 0, 30);
    prog_buf[4]  = enc(2, 0, 2, 0);
    prog_buf[5]  = enc(2, 1, 3, 0);
    prog_buf[6]  = enc(2, 2, 7, 0);
    prog_buf[7]  = enc(2, 3, 8, 0);
    prog_buf[8]  = enc(6, 2, 3, 4);
    prog_buf[9]  = enc(5, 1, 2, 5);
    prog_buf[10] = enc(10, 2, 0, 6);
    prog_buf[11] = enc(11, 7, 8, 9);
    load_prog();
    run_prog(200, cyc, d0);
    chk("t2_cycles", cyc, 65);
    read_rf(4, v); chk("t2_sum_wrap", v, 6);
    read_rf(5, v); chk("t2_sub_wrap", v, 1018);
    read_rf(6, v); chk("t2_div0_res", v, 1023);
    chk("t2_div0_flag", int'(div0), 1);
    read_rf(9, v);
`ifdef CPU_MUL_EN
    chk("t2_mul", v, 176);
`else
    chk("t2_mul_nop", v, 0);
`endif
    run_prog(200, cyc, d0);
    chk("t2_start_clears_div0", d0, 0);

    // Countdown loop: 16 instructions executed
    applyStimulus_reset(1);
    fill_hlt();
    prog_buf[0] = enc(1, 0, 0, 3);
    prog_buf[1] = enc(2, 0, 2, 0);
    prog_buf[2] = enc(4, 0, 2, 6);
    prog_buf[3] = enc(5, 2, 1, 2);
    prog_buf[4] = enc(6, 3, 1, 3);
    prog_buf[5] = enc(9, 0, 0, 2);
    load_prog();
    run_prog(300, cyc, d0);
    chk("t3_cycles", cyc, 80);
    chk("t3_pc", int'(pc), 6);
    read_rf(2, v); chk("t3_rf2", v, 0);
    read_rf(3, v); chk("t3_rf3", v, 3);

    // Program write while busy must be ignored
    applyStimulus_reset(1);
    fill_hlt();
    prog_buf[0] = enc(1, 0, 0, 5);
    prog_buf[1] = enc(2, 0, 4, 0);
    load_prog();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    prog_we = 1'b1; prog_addr = 5'd1; prog_data = enc(1, 0, 0, 9);
    @(negedge clk); prog_we = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin cyc++; @(negedge clk); end
    read_rf(4, v); chk("t4_progwe_busy", v, 5);

    // Reset during EXEC of SUM
    applyStimulus_reset(1);
    fill_hlt();
    prog_buf[0] = enc(6, 1, 1, 4);
    load_prog();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", int'(busy), 0);
    chk("t5_pc", int'(pc), 0);
    read_rf(4, v); chk("t5_rf4", v, 0);
    read_rf(1, v); chk("t5_rf1", v, 1);

    // Random programs, random mid-run resets, stray prog_we/start pulses
    for (int r = 0; r < 12; r++) begin
      applyStimulus_reset(1 + int'($urandom_range(0, 1)));
      foreach (prog_buf[i])
        prog_buf[i] = enc(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 31)), int'($urandom_range(0, 1023)));
      load_prog();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      budget = int'($urandom_range(40, 400));
      for (int c = 0; c < budget && busy; c++) begin
        dbg_addr  = 4'($urandom_range(0, 15));
        prog_we   = ($urandom_range(0, 15) == 0);
        prog_addr = 5'($urandom_range(0, 31));
        prog_data = CMD_W'($urandom);
        start     = ($urandom_range(0, 31) == 0);
        @(negedge clk);
      end
      prog_we = 1'b0; start = 1'b0;
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu_p.md
Name: multicycle_cpu_p

Overview:
- Parametrised successor to the team's 5-stage multicycle accumulator-less CPU.
- Data width, program depth, data-memory depth and register-file depth are parameters.
- Adds a program-load port, start/halt control, a HLT opcode, a divide-by-zero flag and a debug register read port.
- Sits as a standalone core under the lab top level. A testbench or loader fills program memory, then pulses start.

Parameters:
- DATA_W, 10: datapath, RF and data-memory word width.
- CMD_DEPTH, 32: program memory words; power of 2.
- MEM_DEPTH, 32: data memory words; power of 2.
- RF_DEPTH, 16: register count; power of 2, ≥2.
- AW, 5: instruction address-field width; ≥ clog2 of each depth.
- CMD_W, 4+2*AW+DATA_W (derived, localparam): instruction width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin execution at pc=0 (honoured in IDLE/HALT only)
- prog_we  in  1  program memory write strobe
- prog_addr  in  clog2(CMD_DEPTH)  program write address
- prog_data  in  CMD_W  program word
- dbg_addr  in  clog2(RF_DEPTH)  debug register select
- dbg_data  out  DATA_W  RF[dbg_addr], combinational
- pc  out  clog2(CMD_DEPTH)  current program counter
- busy  out  1  high in FETCH..WB
- halted  out  1  high in HALT
- div0  out  1  sticky divide-by-zero flag

Behaviour:
- Instruction fields:
  - op = cmd[CMD_W-1 -: 4]
  - f1 = next AW bits
  - f2 = next AW bits
  - imm = cmd[DATA_W-1:0]
  - f3 = imm[AW-1:0]
  - Address fields are truncated to each target's index width.
- Opcodes:
  - 0 NOP
  - 1 LTM: mem[f1] <= imm
  - 2 MTR: RF[f2] <= mem[f1]
  - 3 RTR: RF[f1] <= RF[f2]
  - 4 JL: if RF[f1] < RF[f2] then pc+1, else pc <= f3
  - 5 SUB: RF[f3] <= RF[f1] - RF[f2]
  - 6 SUM: RF[f3] <= RF[f1] + RF[f2]
  - 7 MTRK: RF[f2] <= mem[RF[f1]]
  - 8 RTM: mem[f2] <= RF[f1]
  - 9 JMP: pc <= f3
  - 10 DIV: RF[f3] <= RF[f1] / RF[f2]
  - 11 MUL: optional, see below
  - 15 HLT
  - Undefined opcodes execute as NOP.
- Arithmetic:
  - Unsigned, results truncated to DATA_W.
  - SUB and SUM wrap modulo 2^DATA_W.
  - JL compares unsigned.
- DIV by zero: writes all-ones to RF[f3] and sets div0.
- FSM states: IDLE, FETCH, OPA, OPB, EXEC, WB, HALT.
  - IDLE/HALT + start → FETCH next edge. On that edge pc=0 and div0 is cleared.
  - FETCH → OPA → OPB → EXEC → WB, then back to FETCH. Each instruction takes exactly 5 cycles.
  - WB with HLT → HALT, with pc left unchanged.
- Register and memory writes and the pc update all occur on the WB edge only.
- pc increments modulo CMD_DEPTH, so pc = CMD_DEPTH-1 wraps to 0.
- Program load:
  - prog_we is honoured only in IDLE/HALT. It writes prog_data into progmem[prog_addr].
  - prog_we while busy is ignored.
  - prog_we and start in the same cycle: the write completes, then execution starts.
- Reset (also mid-instruction):
  - State → IDLE, pc = 0, div0 = 0.
  - RF cleared except RF[1] = 1.
  - Data memory cleared.
  - Program memory is preserved.
  - Any in-flight write is discarded.
- Reset outputs: busy = 0, halted = 0, div0 = 0, pc = 0.

Optional Feature:
- Macro CPU_MUL_EN.
- Defined: opcode 11 MUL writes RF[f3] <= low DATA_W bits of RF[f1]*RF[f2], using the same 5-cycle timing.
- Undefined: opcode 11 behaves as NOP, and no multiplier is synthesised.

Test Plan:
- Reset, load "LTM mem[3]=7; MTR RF[2]<=mem[3]; HLT", pulse start → halted after 15 cycles from FETCH; dbg_addr=2 reads 7; pc=2.
- RF[2]=7, RF[3]=1023; SUM into RF[4] → RF[4]=6 (wrap). SUB RF[1]-RF[2] into RF[5] → 1018.
- DIV RF[2]/RF[0] into RF[6] → RF[6]=1023, div0=1. A new start clears div0 to 0.
- Countdown loop using JL/SUB/JMP, 3 iterations → correct final register values and total cycle count 5 × executed instructions.
- prog_we pulsed while busy → progmem unchanged. Reset asserted during the EXEC of SUM → destination unchanged, busy=0, pc=0, RF[1]=1.
- With CPU_MUL_EN, RF 40×30 → 1200 mod 1024 = 176. Without CPU_MUL_EN → destination unchanged.
